mem_access_unit: RTL and testbench

Load/store unit between the CPU datapath and the word-only data memory. It converts byte, halfword and word loads and stores into aligned 32-bit memory accesses. Loads are sign- or zero-extended. Sub-word stores use a read-modify-write sequence, because the memory writes whole words only. The CPU is stalled through a `Ready` handshake until each access completes.

---
 rtl/mem_access_pkg.sv | 29 ++
 rtl/mem_access_unit_lane_align.sv | 56 +++++
 rtl/mem_access_unit.sv | 110 +++++++++++
 tb/tb_mem_access_unit.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store unit: access-size encoding, FSM states
// and the alignment/legality check used at request time.
package mem_access_pkg;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Illegal encodings and misaligned halfword/word accesses both fault.
    function automatic logic is_fault(input logic [2:0] op, input logic [1:0] off);
        case (op)
            OP_B, OP_BU: is_fault = 1'b0;
            OP_H, OP_HU: is_fault = off[0];
            OP_W:        is_fault = (off != 2'b00);
            default:     is_fault = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Byte-lane steering: extracts/extends a load lane from a memory word and
// merges store data into the addressed lane(s) of an old word.
module lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] i_load_word,
    input  logic [31:0] i_old_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_op,
    output logic [31:0] o_load_data,
    output logic [31:0] o_store_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_signed;
    logic [31:0] w_rep;
    logic [3:0]  w_be;

    assign w_byte   = i_load_word[8*i_off +: 8];
    assign w_half   = i_off[1] ? i_load_word[31:16] : i_load_word[15:0];
    assign w_signed = ~i_op[2];

    always_comb begin
        o_load_data = i_load_word;
        w_rep       = i_wdata;
        case (i_op[1:0])
            2'b00: begin
                o_load_data = {{24{w_signed & w_byte[7]}}, w_byte};
                w_rep       = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                o_load_data = {{16{w_signed & w_half[15]}}, w_half};
                w_rep       = {2{i_wdata[15:0]}};
            end
            default: begin
                o_load_data = i_load_word;
                w_rep       = i_wdata;
            end
        endcase
    end

    // Replicated store data lets each lane pick either new or old bits independently.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign w_be[gi] = (i_op[1:0] == 2'b10) ||
                              ((i_op[1:0] == 2'b01) && (i_off[1] == LANE[1])) ||
                              ((i_op[1:0] == 2'b00) && (i_off == LANE));
            assign o_store_word[8*gi +: 8] = w_be[gi] ? w_rep[8*gi +: 8]
                                                      : i_old_word[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: turns byte/halfword/word CPU accesses into aligned word
// accesses, using read-modify-write for sub-word stores.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Req,
    input  logic              Wr,
    input  logic [2:0]        Op,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [31:0]       WData,
    output logic [31:0]       RData,
    output logic              Ready,
    output logic              Fault,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [31:0]       MemDin,
    output logic              MemWe,
    input  logic [31:0]       MemDout
);

    state_t            r_state;
    state_t            w_state_next;
    logic [2:0]        r_op;
    logic [1:0]        r_off;
    logic [31:0]       r_wdata;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_merge;
    logic [31:0]       r_rdata;
    logic              r_fault;

    logic [2:0]        w_op_norm;
    logic              w_fault;
    logic [31:0]       w_load_data;
    logic [31:0]       w_store_word;

    // Unsigned sizes have no meaning for stores; fold them onto the signed codes.
    assign w_op_norm = (Wr && (Op == OP_BU || Op == OP_HU)) ? {1'b0, Op[1:0]} : Op;
    assign w_fault   = is_fault(w_op_norm, Addr[1:0]);

    lane_align u_lane_align (
        .i_load_word  (MemDout),
        .i_old_word   (r_merge),
        .i_wdata      (r_wdata),
        .i_off        (r_off),
        .i_op         (r_op),
        .o_load_data  (w_load_data),
        .o_store_word (w_store_word)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state    <= ST_IDLE;
            r_op       <= OP_B;
            r_off      <= 2'b00;
            r_wdata    <= '0;
            r_mem_addr <= '0;
            r_merge    <= '0;
            r_rdata    <= '0;
            r_fault    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    if (Req) begin
                        r_op       <= w_op_norm;
                        r_off      <= Addr[1:0];
                        r_wdata    <= WData;
                        r_mem_addr <= {Addr[ADDR_W-1:2], 2'b00};
                        r_fault    <= w_fault;
                    end
                end
                ST_LOAD: r_rdata <= w_load_data;
                ST_READ: r_merge <= MemDout;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (Req) begin
                    if (w_fault)            w_state_next = ST_DONE;
                    else if (!Wr)           w_state_next = ST_LOAD;
                    else if (w_op_norm == OP_W) w_state_next = ST_WRITE;
                    else                    w_state_next = ST_READ;
                end
            end
            ST_LOAD:  w_state_next = ST_DONE;
            ST_READ:  w_state_next = ST_WRITE;
            ST_WRITE: w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        MemWe   = (r_state == ST_WRITE);
        Ready   = (r_state == ST_DONE);
        Fault   = (r_state == ST_DONE) && r_fault;
        MemDin  = (r_op == OP_W) ? r_wdata : w_store_word;
        MemAddr = r_mem_addr;
        RData   = r_rdata;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small word memory model.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Req = 1'b0;
    logic        Wr = 1'b0;
    logic [2:0]  Op = 3'b000;
    logic [31:0] Addr = '0;
    logic [31:0] WData = '0;
    logic [31:0] RData;
    logic        Ready;
    logic        Fault;
    logic [31:0] MemAddr;
    logic [31:0] MemDin;
    logic        MemWe;
    logic [31:0] MemDout;

    logic [31:0] mem [16];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 Clk = ~Clk;

    assign MemDout = mem[MemAddr[5:2]];
    always @(posedge Clk) if (MemWe) mem[MemAddr[5:2]] <= MemDin;

    mem_access_unit #(.ADDR_W(32)) dut (
        .Clk(Clk), .Rst(Rst), .Req(Req), .Wr(Wr), .Op(Op), .Addr(Addr),
        .WData(WData), .RData(RData), .Ready(Ready), .Fault(Fault),
        .MemAddr(MemAddr), .MemDin(MemDin), .MemWe(MemWe), .MemDout(MemDout)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One access from an IDLE cycle; Req drops after acceptance, which must not matter.
    task automatic access(input string tag, input logic wr, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int exp_lat, input int exp_we, input logic [31:0] exp_din,
                          input logic exp_fault, input logic [31:0] exp_rdata);
        int lat;
        int we_cnt;
        logic [31:0] din;
        Req = 1'b1; Wr = wr; Op = op; Addr = addr; WData = wdata;
        @(posedge Clk); #1;
        Req = 1'b0; Wr = 1'b0; Op = 3'b000; Addr = '0; WData = '0;
        lat = 1; we_cnt = 0; din = '0;
        while (!Ready && lat < 10) begin
            if (MemWe) begin we_cnt++; din = MemDin; end
            @(posedge Clk); #1;
            lat++;
        end
        if (MemWe) we_cnt++;
        check_val({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check_val({tag, " we_cycles"}, 32'(we_cnt), 32'(exp_we));
        if (exp_we > 0) check_val({tag, " memdin"}, din, exp_din);
        check_val({tag, " fault"}, {31'b0, Fault}, {31'b0, exp_fault});
        check_val({tag, " rdata"}, RData, exp_rdata);
        $display("txn %s wr=%0b op=%03b addr=0x%08h lat=%0d fault=%0b rdata=0x%08h",
                 tag, wr, op, addr, lat, Fault, RData);
        @(posedge Clk); #1;
    endtask

    initial begin
        int cyc;
        int k;
        int we_seen;
        int rdy_cyc [3];
        logic [31:0] b2b_addr [3];
        logic [31:0] b2b_exp [3];

        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[4] = 32'h80FF7F01;
        mem[3] = 32'hCAFEBABE;
        mem[1] = 32'h5A5A5A5A;

        #12;
        check_val("rst rdata", RData, 32'h0);
        check_val("rst ready", {31'b0, Ready}, 32'h0);
        check_val("rst fault", {31'b0, Fault}, 32'h0);
        check_val("rst memwe", {31'b0, MemWe}, 32'h0);
        check_val("rst memaddr", MemAddr, 32'h0);
        check_val("rst memdin", MemDin, 32'h0);
        Rst = 1'b0;
        @(posedge Clk); #1;

        access("SW08", 1'b1, OP_W, 32'h08, 32'h11223344, 2, 1, 32'h11223344, 1'b0, 32'h0);
        check_val("SW08 mem", mem[2], 32'h11223344);
        access("LW08", 1'b0, OP_W, 32'h08, 32'h0, 2, 0, 32'h0, 1'b0, 32'h11223344);
        access("LB13", 1'b0, OP_B, 32'h13, 32'h0, 2, 0, 32'h0, 1'b0, 32'hFFFFFF80);
        access("LBU13", 1'b0, OP_BU, 32'h13, 32'h0, 2, 0, 32'h0, 1'b0, 32'h00000080);
        access("LB11", 1'b0, OP_B, 32'h11, 32'h0, 2, 0, 32'h0, 1'b0, 32'h0000007F);
        access("LH12", 1'b0, OP_H, 32'h12, 32'h0, 2, 0, 32'h0, 1'b0, 32'hFFFF80FF);
        access("LHU12", 1'b0, OP_HU, 32'h12, 32'h0, 2, 0, 32'h0, 1'b0, 32'h000080FF);
        access("SB0A", 1'b1, OP_B, 32'h0A, 32'h000000AB, 3, 1, 32'h11AB3344, 1'b0, 32'h000080FF);
        check_val("SB0A mem", mem[2], 32'h11AB3344);
        access("SHU08", 1'b1, OP_HU, 32'h08, 32'h0000BEEF, 3, 1, 32'h11ABBEEF, 1'b0, 32'h000080FF);
        access("LH03", 1'b0, OP_H, 32'h03, 32'h0, 1, 0, 32'h0, 1'b1, 32'h000080FF);
        access("SW06", 1'b1, OP_W, 32'h06, 32'hDEADBEEF, 1, 0, 32'h0, 1'b1, 32'h000080FF);
        check_val("SW06 mem", mem[1], 32'h5A5A5A5A);
        access("OP111", 1'b0, 3'b111, 32'h00, 32'h0, 1, 0, 32'h0, 1'b1, 32'h000080FF);

        // Reset lands while the SH is in its READ cycle.
        Req = 1'b1; Wr = 1'b1; Op = OP_H; Addr = 32'h0E; WData = 32'h00001234;
        @(posedge Clk); #1;
        Req = 1'b0; Wr = 1'b0;
        check_val("rstmid in_read", {29'b0, dut.r_state}, {29'b0, ST_READ});
        #1 Rst = 1'b1;
        #1;
        check_val("rstmid state", {29'b0, dut.r_state}, {29'b0, ST_IDLE});
        check_val("rstmid memaddr", MemAddr, 32'h0);
        #1 Rst = 1'b0;
        we_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge Clk); #1;
            if (MemWe) we_seen++;
        end
        check_val("rstmid we_cycles", 32'(we_seen), 32'h0);
        check_val("rstmid mem", mem[3], 32'hCAFEBABE);
        $display("txn RSTMID SH addr=0x0000000e we_cycles=%0d mem=0x%08h", we_seen, mem[3]);

        // Three loads with Req held high; each new address is presented during DONE.
        b2b_addr[0] = 32'h08; b2b_exp[0] = 32'h11ABBEEF;
        b2b_addr[1] = 32'h10; b2b_exp[1] = 32'h80FF7F01;
        b2b_addr[2] = 32'h0C; b2b_exp[2] = 32'hCAFEBABE;
        k = 0; cyc = 0;
        Req = 1'b1; Wr = 1'b0; Op = OP_W; Addr = b2b_addr[0];
        while (k < 3 && cyc < 20) begin
            @(posedge Clk); #1;
            cyc++;
            if (Ready) begin
                rdy_cyc[k] = cyc;
                check_val($sformatf("B2B%0d rdata", k), RData, b2b_exp[k]);
                $display("txn B2B%0d addr=0x%08h cycle=%0d rdata=0x%08h", k, b2b_addr[k], cyc, RData);
                k++;
                if (k < 3) Addr = b2b_addr[k];
            end
        end
        Req = 1'b0;
        check_val("B2B count", 32'(k), 32'd3);
        if (k == 3) begin
            check_val("B2B first", 32'(rdy_cyc[0]), 32'd2);
            check_val("B2B gap1", 32'(rdy_cyc[1] - rdy_cyc[0]), 32'd3);
            check_val("B2B gap2", 32'(rdy_cyc[2] - rdy_cyc[1]), 32'd3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
